// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit CPU core.
// Define CTRL_TIMEOUT_EN to add the ack watchdog that drops a stalled request and sets err.
module cpu_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        ifetch_req,
    output logic [7:0]  ifetch_addr,
    input  logic        ifetch_ack,
    input  logic [15:0] instr,
    output logic [2:0]  alufn,
    output logic        alu_bsel,
    output logic [7:0]  imm,
    output logic [2:0]  rf_raddr_a,
    output logic [2:0]  rf_raddr_b,
    output logic [2:0]  rf_waddr,
    output logic        rf_we,
    output logic        rf_wsel,
    input  logic [7:0]  aluout,
    input  logic        br,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [7:0]  dmem_addr,
    input  logic        dmem_ack,
    output logic [7:0]  pc,
    output logic        err
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    state_t      state;
    logic [2:0]  op;
    logic [2:0]  dst;
    logic        pend;
    logic        tmo;
    // pend keeps the fetch request alive once issued, so a late drop of run cannot abandon it
    assign ifetch_req  = (state == FETCH) && (run || pend);
    assign ifetch_addr = pc;
`ifdef CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          waiting;
    assign waiting = (ifetch_req && !ifetch_ack) || (dmem_req && !dmem_ack);
    assign tmo     = waiting && (cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (!waiting || tmo) ? '0 : cnt + 1'b1;
            err <= err | tmo;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= 8'h00;
            pend       <= 1'b0;
            op         <= 3'd0;
            dst        <= 3'd0;
            alufn      <= 3'd0;
            alu_bsel   <= 1'b0;
            imm        <= 8'h00;
            rf_raddr_a <= 3'd0;
            rf_raddr_b <= 3'd0;
            rf_waddr   <= 3'd0;
            rf_we      <= 1'b0;
            rf_wsel    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 8'h00;
        end else begin
            rf_we <= 1'b0;
            if (tmo) begin
                pend     <= 1'b0;
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
                pc       <= pc + 8'd1;
                state    <= FETCH;
            end else begin
                case (state)
                    FETCH: begin
                        pend <= ifetch_req && !ifetch_ack;
                        if (ifetch_req && ifetch_ack) begin
                            op         <= instr[15:13];
                            dst        <= instr[12:10];
                            imm        <= {instr[6], instr[6:0]};
                            rf_raddr_a <= instr[9:7];
                            rf_raddr_b <= instr[15] ? instr[12:10] : instr[6:4];
                            state      <= DECODE;
                        end
                    end
                    DECODE: begin
                        alufn    <= op;
                        alu_bsel <= (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
                        state    <= EXEC;
                    end
                    EXEC: begin
                        dmem_addr <= aluout;
                        if (op == 3'd7) begin
                            pc    <= pc + 8'd1 + (br ? imm : 8'd0);
                            state <= FETCH;
                        end else if (op == 3'd5 || op == 3'd6) begin
                            dmem_req <= 1'b1;
                            dmem_we  <= (op == 3'd6);
                            state    <= MEM;
                        end else begin
                            rf_we    <= (dst != 3'd0);
                            rf_waddr <= dst;
                            rf_wsel  <= 1'b0;
                            state    <= WB;
                        end
                    end
                    MEM: begin
                        if (dmem_ack) begin
                            dmem_req <= 1'b0;
                            dmem_we  <= 1'b0;
                            if (op == 3'd6) begin
                                pc    <= pc + 8'd1;
                                state <= FETCH;
                            end else begin
                                rf_we    <= (dst != 3'd0);
                                rf_waddr <= dst;
                                rf_wsel  <= 1'b1;
                                state    <= WB;
                            end
                        end
                    end
                    WB: begin
                        pc    <= pc + 8'd1;
                        state <= FETCH;
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed plus randomized checks of cpu_ctrl against an instruction-level model.
module tb_cpu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        ifetch_req;
    logic [7:0]  ifetch_addr;
    logic        ifetch_ack = 1'b0;
    logic [15:0] instr = 16'h0;
    logic [2:0]  alufn;
    logic        alu_bsel;
    logic [7:0]  imm;
    logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        rf_we, rf_wsel;
    logic [7:0]  aluout = 8'h0;
    logic        br = 1'b0;
    logic        dmem_req, dmem_we;
    logic [7:0]  dmem_addr;
    logic        dmem_ack = 1'b0;
    logic [7:0]  pc;
    logic        err;

    int tests = 0;
    int fails = 0;
    logic [7:0] mpc = 8'h00;

    cpu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_ack(ifetch_ack), .instr(instr),
        .alufn(alufn), .alu_bsel(alu_bsel), .imm(imm),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .aluout(aluout), .br(br),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
        .pc(pc), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from the current negedge until the next fetch request appears.
    task automatic exec(input logic [15:0] iw, input logic [7:0] av, input logic bv, input int fw, input int mw);
        logic [2:0] op = iw[15:13];
        logic [7:0] sx = {iw[6], iw[6:0]};
        logic is_mem = (op == 3'd5) || (op == 3'd6);
        logic to = 1'b0;
        logic exp_we;
        logic [7:0] exp_pc;
        int exp_lat, exp_mreq;
        int s = -1, fa = -1, fwc = 0, mwc = 0, wes = 0, mreq = 0, lat = -1;
        logic [2:0] wa = 3'd0;
        logic ws = 1'b0;
        logic fetched = 1'b0;
`ifdef CTRL_TIMEOUT_EN
        to = is_mem && (mw >= 15);
`endif
        exp_we   = !to && (op != 3'd6) && (op != 3'd7) && (iw[12:10] != 3'd0);
        exp_pc   = (op == 3'd7 && bv) ? mpc + 8'd1 + sx : mpc + 8'd1;
        exp_mreq = !is_mem ? 0 : (to ? 15 : mw + 1);
        exp_lat  = to ? 18 + fw : (op == 3'd7 ? 3 : (op == 3'd5 ? 5 : 4)) + fw + (is_mem ? mw : 0);
        instr = iw; aluout = av; br = bv; run = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ifetch_ack = 1'b0;
            dmem_ack = 1'b0;
            if (ifetch_req && fetched) begin
                lat = i - s;
                break;
            end
            if (ifetch_req) begin
                if (s < 0) begin
                    s = i;
                    chk("ifetch_addr", {24'h0, ifetch_addr}, {24'h0, mpc});
                end
                ifetch_ack = (fwc == fw);
                fwc++;
                if (ifetch_ack) begin
                    fetched = 1'b1;
                    fa = i;
                end
            end
            if (fa >= 0 && i == fa + 1) begin
                chk("raddr_a", {29'h0, rf_raddr_a}, {29'h0, iw[9:7]});
                chk("raddr_b", {29'h0, rf_raddr_b}, {29'h0, (op[2] ? iw[12:10] : iw[6:4])});
            end
            if (fa >= 0 && i == fa + 2) begin
                chk("alufn", {29'h0, alufn}, {29'h0, op});
                chk("alu_bsel", {31'h0, alu_bsel}, {31'h0, (op >= 3'd4 && op <= 3'd6)});
                chk("imm", {24'h0, imm}, {24'h0, sx});
            end
            if (dmem_req) begin
                mreq++;
                if (mreq == 1) begin
                    chk("dmem_addr", {24'h0, dmem_addr}, {24'h0, av});
                    chk("dmem_we", {31'h0, dmem_we}, {31'h0, (op == 3'd6)});
                end
                dmem_ack = (mwc == mw);
                mwc++;
            end
            if (rf_we) begin
                wes++;
                wa = rf_waddr;
                ws = rf_wsel;
            end
            @(negedge clk);
        end
        chk("latency", lat, exp_lat);
        chk("pc", {24'h0, pc}, {24'h0, exp_pc});
        chk("rf_we_cycles", wes, exp_we ? 1 : 0);
        if (exp_we) begin
            chk("rf_waddr", {29'h0, wa}, {29'h0, iw[12:10]});
            chk("rf_wsel", {31'h0, ws}, {31'h0, (op == 3'd5)});
        end
        chk("dmem_req_cycles", mreq, exp_mreq);
        mpc = exp_pc;
    endtask

    // Branches (br=1) toward target in steps the 7-bit offset can reach.
    task automatic hop(input logic [7:0] target);
        for (int k = 0; k < 8 && mpc != target; k++) begin
            logic [7:0] dd = target - mpc - 8'd1;
            int sd = int'($signed(dd));
            logic [7:0] t;
            if (sd > 63) sd = 63;
            if (sd < -64) sd = -64;
            t = sd[7:0];
            exec({3'b111, 3'd1, 3'd2, t[6:0]}, 8'h00, 1'b1, 0, 0);
        end
    endtask

    initial begin
        logic exp_err;
        int wes;
        #1;
        chk("rst_pc", {24'h0, pc}, 32'h0);
        chk("rst_ifetch_req", {31'h0, ifetch_req}, 32'h0);
        chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
        chk("rst_rf_we", {31'h0, rf_we}, 32'h0);
        chk("rst_alufn", {29'h0, alufn}, 32'h0);
        chk("rst_bsel", {31'h0, alu_bsel}, 32'h0);
        chk("rst_imm", {24'h0, imm}, 32'h0);
        chk("rst_raddr", {26'h0, rf_raddr_a, rf_raddr_b}, 32'h0);
        chk("rst_waddr", {29'h0, rf_waddr}, 32'h0);
        chk("rst_dmem_addr", {24'h0, dmem_addr}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_run", {31'h0, ifetch_req}, 32'h0);
        exec(16'h0A20, 8'h5A, 1'b0, 0, 0);
        exec(16'hAC85, 8'h15, 1'b0, 0, 3);
        for (int n = 0; n < 25; n++) begin
            exec(16'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        hop(8'h10);
        exec({3'b111, 3'd3, 3'd4, 7'h7D}, 8'h00, 1'b1, 0, 0);
        chk("beq_taken_pc", {24'h0, pc}, 32'h0E);
        hop(8'h10);
        exec({3'b111, 3'd3, 3'd4, 7'h7D}, 8'h00, 1'b0, 1, 0);
        chk("beq_not_taken_pc", {24'h0, pc}, 32'h11);
        exec(16'h0290, 8'h33, 1'b0, 0, 0);
        hop(8'hFF);
        exec(16'h1520, 8'h01, 1'b0, 0, 0);
        chk("pc_wrap", {24'h0, pc}, 32'h00);
        instr = 16'hAC85; aluout = 8'h21; run = 1'b1;
        for (int i = 0; i < 20 && !dmem_req; i++) begin
            ifetch_ack = ifetch_req;
            @(negedge clk);
        end
        ifetch_ack = 1'b0;
        chk("mid_mem_req", {31'h0, dmem_req}, 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        chk("async_rst_pc", {24'h0, pc}, 32'h0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        wes = 0;
        repeat (4) begin
            @(negedge clk);
            wes += int'(rf_we) + int'(dmem_req);
        end
        dmem_ack = 1'b0;
        chk("late_ack_ignored", wes, 0);
        mpc = 8'h00;
        exec({3'b110, 3'd2, 3'd1, 7'h03}, 8'h44, 1'b0, 0, 40);
        exec({3'b100, 3'd6, 3'd1, 7'h7F}, 8'h10, 1'b0, 2, 0);
`ifdef CTRL_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        chk("err", {31'h0, err}, {31'h0, exp_err});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
